// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the Dmem load/store unit.
// - Dmem access-length codes (*_ME), including NOP_ME for "no access".
// - Helpers that classify a code: load/store, beat count and alignment.
package dmem_lsu_pkg;

    localparam logic [2:0] NOP_ME = 3'd0;
    localparam logic [2:0] LW_ME  = 3'd1;
    localparam logic [2:0] LH_ME  = 3'd2;
    localparam logic [2:0] LB_ME  = 3'd3;
    localparam logic [2:0] LBU_ME = 3'd4;
    localparam logic [2:0] SW_ME  = 3'd5;
    localparam logic [2:0] SH_ME  = 3'd6;
    localparam logic [2:0] SB_ME  = 3'd7;

    function automatic logic is_load(input logic [2:0] code);
        return (code == LW_ME) || (code == LH_ME) || (code == LB_ME) || (code == LBU_ME);
    endfunction

    function automatic logic is_store(input logic [2:0] code);
        return (code == SW_ME) || (code == SH_ME) || (code == SB_ME);
    endfunction

    // Index of the final byte beat when an access is split (N-1).
    function automatic logic [1:0] last_beat(input logic [2:0] code);
        case (code)
            LW_ME, SW_ME: return 2'd3;
            LH_ME, SH_ME: return 2'd1;
            default:      return 2'd0;
        endcase
    endfunction

    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] code, input logic [1:0] addr_lo);
        case (code)
            LW_ME, SW_ME: return addr_lo != 2'd0;
            LH_ME, SH_ME: return addr_lo[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and Dmem bus bundle of the load/store unit.
// - slave : the LSU itself (takes requests, drives the Dmem port).
// - master: the environment (MEM stage driving requests, Dmem returning rdata).
// Signals: req_valid/req_ready/req_we/req_memlen/req_addr/req_wdata,
//          resp_valid/resp_rdata/resp_err,
//          mem_we/mem_memlen/mem_waddr/mem_wdata/mem_rdata.
interface dmem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memlen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_we;
    logic [2:0]  mem_memlen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_memlen, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_memlen, mem_waddr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_memlen, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_memlen, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/dmem_lsu_load_ext.sv
// Combinational load-data extension by access code.
// Ports: memlen (original request code), din (raw LSB-aligned data),
//        dout (sign/zero-extended data; unchanged for lw and non-load codes).
// Idempotent, so data that Dmem already extended passes through unchanged.
module dmem_lsu_load_ext
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  memlen,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        case (memlen)
            LH_ME:   dout = {{16{din[15]}}, din[15:0]};
            LB_ME:   dout = {{24{din[7]}}, din[7:0]};
            LBU_ME:  dout = {24'h0, din[7:0]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the MEM stage and the Dmem port.
// Ports: clk, rst_n (async, active-low), bus (dmem_lsu_if.slave: request,
//        response and Dmem signals), stat_split_cnt (saturating count of
//        requests that took the split path).
// One request in flight. Aligned accesses take one Dmem beat; misaligned
// h/w accesses become per-byte beats (sb for stores, lbu for loads) whose
// load bytes are gathered and then extended by the original code.
// All bus outputs are registered.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter bit SPLIT_EN  = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_lsu_if.slave            bus,
    output logic [CNT_WIDTH-1:0] stat_split_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_SPLIT = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state;
    logic        lat_we;
    logic [2:0]  lat_code;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rd_buf;
    logic [1:0]  beat_cnt;

    logic        accept;
    logic        req_mis;
    logic        req_err;
    logic        req_split;
    logic        last;
    logic [1:0]  nxt_cnt;
    logic [31:0] asm_word;
    logic [31:0] ext_in;
    logic [31:0] ext_out;

    assign accept    = bus.req_valid && bus.req_ready;
    assign req_mis   = is_misaligned(bus.req_memlen, bus.req_addr[1:0]);
    assign req_err   = !(is_load(bus.req_memlen) || is_store(bus.req_memlen))
                     || (bus.req_we != is_store(bus.req_memlen))
                     || (req_mis && !SPLIT_EN);
    assign req_split = !req_err && req_mis;
    assign nxt_cnt   = beat_cnt + 2'd1;
    assign last      = (state == S_BEAT) || (beat_cnt == last_beat(lat_code));

    // Gather buffer with the current beat's byte merged in, so the final
    // beat's data is usable in the same cycle it arrives.
    always_comb begin
        // NOTE: default assignment first so no path leaves asm_word unassigned (no latch).
        asm_word = rd_buf;
        asm_word[8*beat_cnt +: 8] = bus.mem_rdata[7:0];
    end

    assign ext_in = (state == S_BEAT) ? bus.mem_rdata : asm_word;

    dmem_lsu_load_ext u_ext (
        .memlen (lat_code),
        .din    (ext_in),
        .dout   (ext_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lat_we         <= 1'b0;
            lat_code       <= NOP_ME;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            rd_buf         <= '0;
            beat_cnt       <= 2'd0;
            stat_split_cnt <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_memlen <= NOP_ME;
            bus.mem_waddr  <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        lat_we        <= bus.req_we;
                        lat_code      <= bus.req_memlen;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        beat_cnt      <= 2'd0;
                        bus.req_ready <= req_err;
                        if (req_err) begin
                            // No Dmem beat: respond in the very next cycle.
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (req_split) begin
                            state          <= S_SPLIT;
                            bus.mem_we     <= bus.req_we;
                            bus.mem_memlen <= bus.req_we ? SB_ME : LBU_ME;
                            bus.mem_waddr  <= bus.req_addr;
                            bus.mem_wdata  <= {24'h0, bus.req_wdata[7:0]};
                            if (stat_split_cnt != '1) begin
                                stat_split_cnt <= stat_split_cnt + 1'b1;
                            end
                        end else begin
                            state          <= S_BEAT;
                            bus.mem_we     <= bus.req_we;
                            bus.mem_memlen <= bus.req_memlen;
                            bus.mem_waddr  <= bus.req_addr;
                            bus.mem_wdata  <= bus.req_wdata;
                        end
                    end else begin
                        state         <= S_IDLE;
                        bus.req_ready <= 1'b1;
                    end
                end
                S_BEAT, S_SPLIT: begin
                    rd_buf <= asm_word;
                    if (last) begin
                        state          <= S_RESP;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= lat_we ? '0 : ext_out;
                        bus.mem_we     <= 1'b0;
                        bus.mem_memlen <= NOP_ME;
                        bus.mem_waddr  <= '0;
                        bus.mem_wdata  <= '0;
                    end else begin
                        beat_cnt      <= nxt_cnt;
                        bus.mem_waddr <= lat_addr + {30'd0, nxt_cnt};
                        bus.mem_wdata <= {24'h0, lat_wdata[8*nxt_cnt +: 8]};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
